// File: rtl/popcount_frame_accum.sv
// Frame accumulator for per-vector popcounts: sums clamped counts over up to
// FRAME_LEN vectors and presents total, count and threshold flag on a valid/ready register.
module popcount_frame_accum #(
  parameter int DATA_W    = 10,
  parameter int POS_W     = $clog2(DATA_W),
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1),
  parameter int ACC_W     = $clog2(DATA_W * FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W:0]   in_sum,
  input  logic             flush,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_over,
  output logic             err_range
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [POS_W:0]   DATA_MAX = (POS_W + 1)'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  function automatic logic [ACC_W-1:0] clamp_sum(input logic [POS_W:0] x);
    logic [ACC_W-1:0] r;
    if (x > DATA_MAX) begin
      r = ACC_W'(DATA_W);
    end else begin
      r = ACC_W'(x);
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             out_valid_r, out_valid_s;
  logic [ACC_W-1:0] out_total_r, out_total_s;
  logic [CNT_W-1:0] out_count_r, out_count_s;
  logic             out_over_r, out_over_s;
  logic             err_range_r, err_range_s;

  logic             beat_s;
  logic             close_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_sum_s;

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = out_valid_r;
  assign out_total = out_total_r;
  assign out_count = out_count_r;
  assign out_over  = out_over_r;
  assign err_range = err_range_r;

  // Datapath terms for the current cycle, including this cycle's beat if any.
  always_comb begin
    beat_s    = in_valid && in_ready;
    sum_s     = acc_r;
    cnt_sum_s = cnt_r;
    if (beat_s) begin
      sum_s     = acc_r + clamp_sum(in_sum);
      cnt_sum_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
    end else begin
      sum_s     = acc_r;
      cnt_sum_s = cnt_r;
    end
    // An empty frame is never closed, so flush needs a stored or incoming beat.
    close_s = (beat_s && (cnt_r == LAST_CNT)) ||
              (flush && in_ready && ((cnt_r != {CNT_W{1'b0}}) || beat_s));
  end

  // Next-state and next-output selection.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    out_valid_s = out_valid_r;
    out_total_s = out_total_r;
    out_count_s = out_count_r;
    out_over_s  = out_over_r;
    err_range_s = err_range_r;

    if (beat_s && (in_sum > DATA_MAX)) begin
      err_range_s = 1'b1;
    end else begin
      err_range_s = err_range_r;
    end

    case (state_r)
      ACCUM: begin
        if (close_s) begin
          out_total_s = sum_s;
          out_count_s = cnt_sum_s;
          out_over_s  = (sum_s >= thresh);
          out_valid_s = 1'b1;
          acc_s       = {ACC_W{1'b0}};
          cnt_s       = {CNT_W{1'b0}};
          state_s     = HOLD;
        end else begin
          acc_s = sum_s;
          cnt_s = cnt_sum_s;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = ACCUM;
        end else begin
          out_valid_s = 1'b1;
          state_s     = HOLD;
        end
      end
      default: begin
        state_s     = ACCUM;
        out_valid_s = 1'b0;
        acc_s       = {ACC_W{1'b0}};
        cnt_s       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ACCUM;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_total_r <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_over_r  <= 1'b0;
      err_range_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      out_valid_r <= out_valid_s;
      out_total_r <= out_total_s;
      out_count_r <= out_count_s;
      out_over_r  <= out_over_s;
      err_range_r <= err_range_s;
    end
  end

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed bench for popcount_frame_accum with DATA_W=10, FRAME_LEN=4.
module tb_popcount_frame_accum;

  localparam int DATA_W    = 10;
  localparam int FRAME_LEN = 4;
  localparam int POS_W     = 4;
  localparam int CNT_W     = 3;
  localparam int ACC_W     = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [POS_W:0]   in_sum;
  logic             flush;
  logic [ACC_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             out_over;
  logic             err_range;

  int total = 0;
  int bad   = 0;

  popcount_frame_accum #(
    .DATA_W(DATA_W),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .flush(flush),
    .thresh(thresh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_count(out_count),
    .out_over(out_over),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [POS_W:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input int t, input int c, input logic o);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_total"}, 32'(out_total), t);
    chk({tag, "_count"}, 32'(out_count), c);
    chk({tag, "_over"},  32'(out_over),  32'(o));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = 5'd0; flush = 1'b0;
    thresh = 6'd0; out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 0, 0, 1'b0);
    chk("reset_err", 32'(err_range), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // 1: beats 3,10,0,7 -> total 20 on the cycle after the fourth accept
    thresh = 6'd20;
    beat(5'd3);
    beat(5'd10);
    beat(5'd0);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    beat(5'd7);
    chk_out("t1", 1'b1, 20, 4, 1'b1);
    chk("t1_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("t1_pulse_end", 32'(out_valid), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);
    chk("t1_total_kept", 32'(out_total), 32'd20);

    // 2: full frame of 10s with back-pressure
    thresh = 6'd41;
    out_ready = 1'b0;
    beat(5'd10);
    beat(5'd10);
    beat(5'd10);
    beat(5'd10);
    chk_out("t2", 1'b1, 40, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'd10;
      tick();
      chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_total", 32'(out_total), 32'd40);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t2_release_valid", 32'(out_valid), 32'd0);
    chk("t2_release_in_ready", 32'(in_ready), 32'd1);

    // 3: flush together with a beat includes that beat
    thresh = 6'd12;
    beat(5'd5);
    beat(5'd5);
    in_valid = 1'b1; in_sum = 5'd1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk_out("t3", 1'b1, 11, 3, 1'b0);
    tick();
    chk("t3_pulse_end", 32'(out_valid), 32'd0);

    // 4: flush with an empty frame and flush during HOLD are ignored
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    chk("t4_empty_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_empty_flush_ready", 32'(in_ready), 32'd1);
    thresh = 6'd10;
    out_ready = 1'b0;
    beat(5'd1);
    beat(5'd2);
    beat(5'd3);
    chk("t4_not_closed_early", 32'(out_valid), 32'd0);
    beat(5'd4);
    chk_out("t4", 1'b1, 10, 4, 1'b1);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    chk_out("t4_hold_flush", 1'b1, 10, 4, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("t4_release", 32'(out_valid), 32'd0);

    // 5: out-of-range count is clamped and sets sticky error
    thresh = 6'd19;
    chk("t5_err_before", 32'(err_range), 32'd0);
    beat(5'd15);
    chk("t5_err_set", 32'(err_range), 32'd1);
    beat(5'd2);
    beat(5'd3);
    beat(5'd4);
    chk_out("t5", 1'b1, 19, 4, 1'b1);
    tick();
    beat(5'd1);
    in_valid = 1'b1; in_sum = 5'd1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk_out("t5_next_frame", 1'b1, 2, 2, 1'b0);
    chk("t5_err_sticky", 32'(err_range), 32'd1);
    tick();

    // 6: reset discards a partial frame and clears the error
    thresh = 6'd5;
    beat(5'd4);
    beat(5'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_err_cleared", 32'(err_range), 32'd0);
    chk("t6_no_valid", 32'(out_valid), 32'd0);
    beat(5'd1);
    beat(5'd1);
    beat(5'd1);
    chk("t6_partial_not_emitted", 32'(out_valid), 32'd0);
    beat(5'd1);
    chk_out("t6", 1'b1, 4, 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
